// File: rtl/padded_frame_loader.sv
// Streams a W x H raster into a zero-bordered (W+2) x (H+2) frame buffer.
// One registered write per cycle, addresses strictly sequential per frame.
module padded_frame_loader #(
  parameter int W      = 256,
  parameter int H      = 32,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_pixel,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(W + 2);
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] COL_PAD  = CW'(W + 1);
  localparam logic [CW-1:0] COL_DATA = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  typedef enum logic [2:0] {
    IDLE, TOP, LEFT, DATA, RIGHT, BOT, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_cnt_q, col_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr;
  logic [7:0]        wr_data;

  assign in_ready = (state_q == DATA);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr        = 1'b0;
    wr_data   = 8'd0;
    case (state_q)
      IDLE: begin
        // done_q high means FIN was just left; a start here is too early
        if (start && !done_q) begin
          state_d   = TOP;
          busy_d    = 1'b1;
          col_cnt_d = '0;
          row_cnt_d = '0;
        end
      end
      TOP, BOT: begin
        wr = 1'b1;
        if (col_cnt_q == COL_PAD) begin
          col_cnt_d = '0;
          state_d   = (state_q == TOP) ? LEFT : FIN;
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end
      LEFT: begin
        wr      = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        if (in_valid) begin
          wr      = 1'b1;
          wr_data = in_pixel;
          if (col_cnt_q == COL_DATA) begin
            col_cnt_d = '0;
            state_d   = RIGHT;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      RIGHT: begin
        wr = 1'b1;
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_d = '0;
          state_d   = BOT;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = LEFT;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_we_d   = wr;
    mem_addr_d = wr ? addr_cnt_q : mem_addr_q;
    mem_data_d = wr ? wr_data : mem_data_q;
    addr_cnt_d = wr ? addr_cnt_q + 1'b1 : addr_cnt_q;
    if (state_q == IDLE && start && !done_q) begin
      addr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      addr_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_padded_frame_loader.sv
// Bench for padded_frame_loader: a 4x2 instance for scenarios and a
// default-size instance for the full frame; expected images are queued up front.
module tb_padded_frame_loader;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int SN = (SW + 2) * (SH + 2);
  localparam int BW = 256;
  localparam int BH = 32;
  localparam int BN = (BW + 2) * (BH + 2);

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic       s_start = 0, s_valid = 0;
  logic [7:0] s_pixel = 0;
  logic       s_ready, s_we, s_busy, s_done;
  logic [4:0] s_addr;
  logic [7:0] s_data;

  logic        b_start = 0, b_valid = 0;
  logic [7:0]  b_pixel = 0;
  logic        b_ready, b_we, b_busy, b_done;
  logic [14:0] b_addr;
  logic [7:0]  b_data;

  padded_frame_loader #(.W(SW), .H(SH), .ADDR_W(5)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
    .in_pixel(s_pixel), .in_ready(s_ready), .mem_we(s_we),
    .mem_addr(s_addr), .mem_data(s_data), .busy(s_busy), .done(s_done)
  );

  padded_frame_loader u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid),
    .in_pixel(b_pixel), .in_ready(b_ready), .mem_we(b_we),
    .mem_addr(b_addr), .mem_data(b_data), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  int         exp_a[$];
  logic [7:0] exp_d[$];
  int         got_a[$];
  logic [7:0] got_d[$];
  int         done_cnt = 0, done_ok = 0;
  logic       prev_we = 0;
  int         prev_addr = 0;

  int         bgot_a[$];
  logic [7:0] bgot_d[$];
  int         bdone_cnt = 0, bdone_ok = 0;
  logic       bprev_we = 0;
  int         bprev_addr = 0;

  always @(negedge clk) begin
    if (s_we) begin
      got_a.push_back(int'(s_addr));
      got_d.push_back(s_data);
    end
    if (s_done) begin
      done_cnt++;
      if (prev_we && prev_addr == SN - 1) done_ok++;
    end
    prev_we   = s_we;
    prev_addr = int'(s_addr);
  end

  always @(negedge clk) begin
    if (b_we) begin
      bgot_a.push_back(int'(b_addr));
      bgot_d.push_back(b_data);
    end
    if (b_done) begin
      bdone_cnt++;
      if (bprev_we && bprev_addr == BN - 1) bdone_ok++;
    end
    bprev_we   = b_we;
    bprev_addr = int'(b_addr);
  end

  function automatic logic [7:0] pix(input int idx, input bit big);
    int t;
    t = big ? idx : idx + 1;
    return t[7:0];
  endfunction

  task automatic clr();
    exp_a.delete(); exp_d.delete();
    got_a.delete(); got_d.delete();
    bgot_a.delete(); bgot_d.delete();
    done_cnt = 0; done_ok = 0;
    bdone_cnt = 0; bdone_ok = 0;
  endtask

  task automatic push_image(input int w, input int h, input bit big);
    int r, c;
    for (int a = 0; a < (w + 2) * (h + 2); a++) begin
      r = a / (w + 2);
      c = a % (w + 2);
      exp_a.push_back(a);
      if (r >= 1 && r <= h && c >= 1 && c <= w)
        exp_d.push_back(pix((r - 1) * w + (c - 1), big));
      else
        exp_d.push_back(8'd0);
    end
  endtask

  task automatic drive_small(input bit toggle, input bit spam,
                             input int stop_after, output int first_rdy);
    int idx;
    bit acc, seen_done;
    idx = 0; acc = 0; seen_done = 0; first_rdy = -1;
    @(negedge clk);
    s_start = 1;
    s_valid = 1;
    s_pixel = pix(0, 0);
    acc = s_ready && s_valid;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      if (acc) idx++;
      if (seen_done) break;
      if (stop_after > 0 && idx == stop_after) break;
      s_start = spam;
      s_valid = toggle ? cyc[0] : 1'b1;
      s_pixel = pix(idx, 0);
      if (s_ready && first_rdy < 0) first_rdy = cyc;
      acc = s_ready && s_valid;
      if (s_done) seen_done = 1;
    end
    s_start = 0;
    s_valid = 0;
    if (stop_after == 0) begin
      checks++;
      if (!seen_done) begin
        errors++;
        $display("FAIL frame_timeout: done=0 required 1");
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, s_we, s_busy, s_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_s_ctl: got %b required 0000",
               {s_ready, s_we, s_busy, s_done});
    end
    checks++;
    if ({s_addr, s_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_s_port: addr %0d data %0d required 0 0", s_addr, s_data);
    end
    checks++;
    if ({b_ready, b_we, b_busy, b_done, b_addr, b_data} !== 27'd0) begin
      errors++;
      $display("FAIL reset_big: got %h required 0",
               {b_ready, b_we, b_busy, b_done, b_addr, b_data});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int fr;
    clr();
    push_image(SW, SH, 0);
    drive_small(0, 0, 0, fr);
    repeat (4) @(negedge clk);
    checks++;
    if (got_a.size() != SN) begin
      errors++;
      $display("FAIL basic_count: got %0d required %0d", got_a.size(), SN);
    end
    while (exp_a.size() > 0 && got_a.size() > 0) begin
      int ea, ga;
      logic [7:0] ed, gd;
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      ga = got_a.pop_front(); gd = got_d.pop_front();
      checks++;
      if (ga !== ea || gd !== ed) begin
        errors++;
        $display("FAIL basic_word: addr %0d data %0d required addr %0d data %0d",
                 ga, gd, ea, ed);
      end
    end
    checks++;
    if (done_cnt != 1 || done_ok != 1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: cnt %0d timed %0d busy %b required 1 1 0",
               done_cnt, done_ok, s_busy);
    end
  endtask

  task automatic test_stall();
    int fr;
    clr();
    push_image(SW, SH, 0);
    drive_small(1, 0, 0, fr);
    repeat (4) @(negedge clk);
    checks++;
    if (got_a.size() != SN) begin
      errors++;
      $display("FAIL stall_count: got %0d required %0d", got_a.size(), SN);
    end
    while (exp_a.size() > 0 && got_a.size() > 0) begin
      int ea, ga;
      logic [7:0] ed, gd;
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      ga = got_a.pop_front(); gd = got_d.pop_front();
      checks++;
      if (ga !== ea || gd !== ed) begin
        errors++;
        $display("FAIL stall_word: addr %0d data %0d required addr %0d data %0d",
                 ga, gd, ea, ed);
      end
    end
    checks++;
    if (done_cnt != 1 || done_ok != 1) begin
      errors++;
      $display("FAIL stall_done: cnt %0d timed %0d required 1 1", done_cnt, done_ok);
    end
  endtask

  task automatic test_idle_valid();
    int fr;
    clr();
    s_valid = 1;
    s_pixel = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || s_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready: ready %b we %b required 0 0", s_ready, s_we);
      end
    end
    push_image(SW, SH, 0);
    drive_small(0, 0, 0, fr);
    repeat (4) @(negedge clk);
    checks++;
    if (fr != SW + 4) begin
      errors++;
      $display("FAIL first_ready: cycle %0d required %0d", fr, SW + 4);
    end
    checks++;
    if (got_a.size() != SN || got_a[SW + 3] != SW + 3 || got_d[SW + 3] !== 8'd1) begin
      errors++;
      $display("FAIL first_pixel: writes %0d required %0d, pixel 1 at addr %0d",
               got_a.size(), SN, SW + 3);
    end
  endtask

  task automatic test_reset_mid();
    int fr;
    clr();
    drive_small(0, 0, 3, fr);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({s_ready, s_we, s_busy, s_done} !== 4'b0 || {s_addr, s_data} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_out: ctl %b addr %0d data %0d required 0",
               {s_ready, s_we, s_busy, s_done}, s_addr, s_data);
    end
    rst_n = 1;
    clr();
    repeat (5) @(negedge clk);
    checks++;
    if (got_a.size() != 0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: writes %0d busy %b required 0 0",
               got_a.size(), s_busy);
    end
    push_image(SW, SH, 0);
    drive_small(0, 0, 0, fr);
    repeat (4) @(negedge clk);
    checks++;
    if (got_a.size() != SN) begin
      errors++;
      $display("FAIL reload_count: got %0d required %0d", got_a.size(), SN);
    end
    while (exp_a.size() > 0 && got_a.size() > 0) begin
      int ea, ga;
      logic [7:0] ed, gd;
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      ga = got_a.pop_front(); gd = got_d.pop_front();
      checks++;
      if (ga !== ea || gd !== ed) begin
        errors++;
        $display("FAIL reload_word: addr %0d data %0d required addr %0d data %0d",
                 ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_start_ignored();
    int fr;
    clr();
    push_image(SW, SH, 0);
    drive_small(0, 1, 0, fr);
    repeat (10) @(negedge clk);
    checks++;
    if (got_a.size() != SN) begin
      errors++;
      $display("FAIL spam_count: got %0d required %0d", got_a.size(), SN);
    end
    checks++;
    if (done_cnt != 1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL spam_done: cnt %0d busy %b required 1 0", done_cnt, s_busy);
    end
    while (exp_a.size() > 0 && got_a.size() > 0) begin
      int ea, ga;
      logic [7:0] ed, gd;
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      ga = got_a.pop_front(); gd = got_d.pop_front();
      checks++;
      if (ga !== ea || gd !== ed) begin
        errors++;
        $display("FAIL spam_word: addr %0d data %0d required addr %0d data %0d",
                 ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_full_frame();
    int idx;
    bit acc, seen;
    clr();
    push_image(BW, BH, 1);
    idx = 0; seen = 0;
    @(negedge clk);
    b_start = 1;
    b_valid = 1;
    b_pixel = pix(0, 1);
    acc = b_ready;
    for (int cyc = 1; cyc < 12000; cyc++) begin
      @(negedge clk);
      if (acc) idx++;
      if (seen) break;
      b_start = 0;
      b_pixel = pix(idx, 1);
      acc = b_ready && b_valid;
      if (b_done) seen = 1;
    end
    b_start = 0;
    b_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || bgot_a.size() != BN || idx != BW * BH) begin
      errors++;
      $display("FAIL big_count: done %b writes %0d pixels %0d required 1 %0d %0d",
               seen, bgot_a.size(), idx, BN, BW * BH);
    end
    checks++;
    if (bdone_cnt != 1 || bdone_ok != 1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL big_done: cnt %0d timed %0d busy %b required 1 1 0",
               bdone_cnt, bdone_ok, b_busy);
    end
    while (exp_a.size() > 0 && bgot_a.size() > 0) begin
      int ea, ga;
      logic [7:0] ed, gd;
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      ga = bgot_a.pop_front(); gd = bgot_d.pop_front();
      checks++;
      if (ga !== ea || gd !== ed) begin
        errors++;
        $display("FAIL big_word: addr %0d data %0d required addr %0d data %0d",
                 ga, gd, ea, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_idle_valid();
    test_reset_mid();
    test_start_ignored();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
